mdio_access_arbiter: RTL and testbench

- Shares one MDIO master engine (start/done command interface, MDC/MDIO pin driver) between two requesters.
- Requester 0: PHY register configuration sequencer. Requester 1: runtime link/status poller.
- Serialises register accesses with a round-robin grant and a timeout guard. Returns read data, a completion pulse and an error flag to the requester that owns the access.

---
 rtl/mdio_access_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mdio_access_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_access_arbiter.sv
// Two-requester arbiter in front of a single MDIO master engine: round-robin grant, timeout guard, per-requester response.
// Optional MDIO_ARB_FIXED_PRIO_EN: requester 0 always wins contention (bring-up mode).
module mdio_access_arbiter #(
    parameter int TIMEOUT_CYC = 200_000,
    parameter int CNT_W       = 18
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_wr,
    input  logic [4:0]  req0_phy_addr,
    input  logic [4:0]  req0_reg_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_done,
    output logic [15:0] req0_rdata,
    output logic        req0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_wr,
    input  logic [4:0]  req1_phy_addr,
    input  logic [4:0]  req1_reg_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_done,
    output logic [15:0] req1_rdata,
    output logic        req1_err,

    output logic        mdio_start,
    output logic        mdio_wr,
    output logic [4:0]  mdio_phy_addr,
    output logic [4:0]  mdio_reg_addr,
    output logic [15:0] mdio_wdata,
    input  logic        mdio_done,
    input  logic [15:0] mdio_rdata,
    input  logic        mdio_nack
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [4:0]        phy_q, phy_d;
    logic [4:0]        reg_q, reg_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              any_valid;
    logic              sel;
    logic              cap_en;
    logic [15:0]       cap_rdata;
    logic              cap_err;

    assign any_valid = req0_valid | req1_valid;

`ifdef MDIO_ARB_FIXED_PRIO_EN
    assign sel = ~req0_valid;
`else
    // On contention the requester that did not win last time gets the grant.
    assign sel = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
`endif

    assign req0_ready = rst_n && (state_q == IDLE) && any_valid && !sel;
    assign req1_ready = rst_n && (state_q == IDLE) && any_valid &&  sel;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        phy_d        = phy_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        cap_en       = 1'b0;
        cap_rdata    = 16'h0000;
        cap_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    wr_d         = sel ? req1_wr       : req0_wr;
                    phy_d        = sel ? req1_phy_addr : req0_phy_addr;
                    reg_d        = sel ? req1_reg_addr : req0_reg_addr;
                    wdata_d      = sel ? req1_wdata    : req0_wdata;
                    state_d      = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Engine completion takes precedence over a coincident timeout.
                if (mdio_done) begin
                    cap_en    = 1'b1;
                    cap_rdata = wr_q ? 16'h0000 : mdio_rdata;
                    cap_err   = mdio_nack;
                    state_d   = RESP;
                end else if (cnt_q == TO_LAST) begin
                    cap_en    = 1'b1;
                    cap_rdata = 16'hFFFF;
                    cap_err   = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_en) begin
            if (owner_q) begin
                rdata1_d = cap_rdata;
                err1_d   = cap_err;
            end else begin
                rdata0_d = cap_rdata;
                err0_d   = cap_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            phy_q        <= 5'd0;
            reg_q        <= 5'd0;
            wdata_q      <= 16'h0000;
            rdata0_q     <= 16'h0000;
            rdata1_q     <= 16'h0000;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            phy_q        <= phy_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign mdio_start    = (state_q == START);
    assign mdio_wr       = wr_q;
    assign mdio_phy_addr = phy_q;
    assign mdio_reg_addr = reg_q;
    assign mdio_wdata    = wdata_q;

    assign req0_done  = (state_q == RESP) && !owner_q;
    assign req1_done  = (state_q == RESP) &&  owner_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

endmodule

// File: tb/tb_mdio_access_arbiter.sv
// Directed self-checking bench for mdio_access_arbiter with a short timeout and an inline MDIO engine model.
module tb_mdio_access_arbiter;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_wr, req0_done, req0_err;
    logic [4:0]  req0_phy_addr, req0_reg_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_ready, req1_wr, req1_done, req1_err;
    logic [4:0]  req1_phy_addr, req1_reg_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic        mdio_start, mdio_wr, mdio_done, mdio_nack;
    logic [4:0]  mdio_phy_addr, mdio_reg_addr;
    logic [15:0] mdio_wdata, mdio_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdio_access_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_phy_addr(req0_phy_addr), .req0_reg_addr(req0_reg_addr), .req0_wdata(req0_wdata),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_phy_addr(req1_phy_addr), .req1_reg_addr(req1_reg_addr), .req1_wdata(req1_wdata),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mdio_start(mdio_start), .mdio_wr(mdio_wr), .mdio_phy_addr(mdio_phy_addr),
        .mdio_reg_addr(mdio_reg_addr), .mdio_wdata(mdio_wdata),
        .mdio_done(mdio_done), .mdio_rdata(mdio_rdata), .mdio_nack(mdio_nack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_wr = 0; req0_phy_addr = 0; req0_reg_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_wr = 0; req1_phy_addr = 0; req1_reg_addr = 0; req1_wdata = 0;
        mdio_done = 0; mdio_rdata = 0; mdio_nack = 0;
    endtask

    // Engine model: waits for mdio_start, answers after `delay` cycles (never if delay<0), then waits for a done.
    task automatic serve(input int delay, input logic [15:0] rd, input logic nk,
                         input bit drop0, input bit drop1,
                         output int phy, output int who, output logic [15:0] ord,
                         output logic oerr, output int lat);
        int n;
        phy = -1; who = -1; ord = 16'h0000; oerr = 1'b0; lat = -1;
        n = 0;
        while (!mdio_start && n < 60) begin tick(); n++; end
        if (!mdio_start) return;
        phy = int'(mdio_phy_addr);
        if (drop0) req0_valid = 0;
        if (drop1) req1_valid = 0;
        lat = 0;
        if (delay >= 0) begin
            repeat (delay) begin tick(); lat++; end
            mdio_done = 1; mdio_rdata = rd; mdio_nack = nk;
            tick(); lat++;
            mdio_done = 0; mdio_rdata = 0; mdio_nack = 0;
        end
        n = 0;
        while (!(req0_done || req1_done) && n < TO + 20) begin tick(); lat++; n++; end
        if (req0_done) begin who = 0; ord = req0_rdata; oerr = req0_err; end
        else if (req1_done) begin who = 1; ord = req1_rdata; oerr = req1_err; end
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        outs = {req0_ready, req0_done, req0_rdata, req0_err, req1_ready, req1_done, req1_rdata, req1_err};
        checks++;
        if (outs !== 40'h0) begin failures++; $display("FAIL reset_req_outs got=%h exp=0", outs); end
        checks++;
        if ({mdio_start, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata} !== 28'h0) begin
            failures++;
            $display("FAIL reset_mdio_outs got=%h exp=0", {mdio_start, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata});
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_read();
        req0_valid = 1; req0_wr = 0; req0_phy_addr = 5'h01; req0_reg_addr = 5'h01;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        checks++;
        if ({mdio_start, mdio_wr, mdio_phy_addr, mdio_reg_addr} !== {1'b1, 1'b0, 5'h01, 5'h01}) begin
            failures++;
            $display("FAIL single_start got=%b/%b/%h/%h exp=1/0/01/01", mdio_start, mdio_wr, mdio_phy_addr, mdio_reg_addr);
        end
        req0_valid = 0;
        tick();
        checks++;
        if (mdio_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", mdio_start); end
        repeat (9) tick();
        mdio_done = 1; mdio_rdata = 16'h796D; mdio_nack = 0;
        tick();
        mdio_done = 0; mdio_rdata = 0;
        checks++;
        if ({req0_done, req0_rdata, req0_err} !== {1'b1, 16'h796D, 1'b0}) begin
            failures++;
            $display("FAIL single_done got=%b/%h/%b exp=1/796d/0", req0_done, req0_rdata, req0_err);
        end
        checks++;
        if ({req1_done, req1_rdata, req1_err} !== 18'h0) begin
            failures++;
            $display("FAIL single_req1_quiet got=%b/%h/%b exp=0/0000/0", req1_done, req1_rdata, req1_err);
        end
        tick();
        checks++;
        if ({req0_done, req0_rdata} !== {1'b0, 16'h796D}) begin
            failures++;
            $display("FAIL single_hold got=%b/%h exp=0/796d", req0_done, req0_rdata);
        end
    endtask

    task automatic test_contention();
        int phy, who, lat;
        logic [15:0] ord;
        logic oerr;
        int exp_who[4];
        bit d0, d1;
`ifdef MDIO_ARB_FIXED_PRIO_EN
        exp_who = '{0, 0, 0, 1};
`else
        exp_who = '{0, 1, 0, 1};
`endif
        rst_n = 0; tick(); rst_n = 1;
        req0_valid = 1; req0_wr = 1; req0_phy_addr = 5'h01; req0_reg_addr = 5'h00; req0_wdata = 16'h3100;
        req1_valid = 1; req1_wr = 0; req1_phy_addr = 5'h02; req1_reg_addr = 5'h01; req1_wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
`ifdef MDIO_ARB_FIXED_PRIO_EN
            d0 = (i == 2); d1 = (i == 3);
`else
            d0 = (i == 3); d1 = (i == 3);
`endif
            serve(2, 16'hABCD, 1'b0, d0, d1, phy, who, ord, oerr, lat);
            checks++;
            if (who !== exp_who[i] || phy !== exp_who[i] + 1) begin
                failures++;
                $display("FAIL contention_order[%0d] got=owner%0d/phy%0d exp=owner%0d/phy%0d", i, who, phy, exp_who[i], exp_who[i] + 1);
            end
            if (i == 0) begin
                checks++;
                if ({mdio_wr, mdio_reg_addr, mdio_wdata, ord, oerr} !== {1'b1, 5'h00, 16'h3100, 16'h0000, 1'b0}) begin
                    failures++;
                    $display("FAIL contention_write got=%b/%h/%h/%h/%b exp=1/00/3100/0000/0", mdio_wr, mdio_reg_addr, mdio_wdata, ord, oerr);
                end
            end
            if (i == 1 && exp_who[i] == 1) begin
                checks++;
                if ({ord, oerr} !== {16'hABCD, 1'b0}) begin
                    failures++;
                    $display("FAIL contention_read got=%h/%b exp=abcd/0", ord, oerr);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        int phy, who, lat;
        logic [15:0] ord;
        logic oerr;
        req1_valid = 1; req1_wr = 0; req1_phy_addr = 5'h02; req1_reg_addr = 5'h01;
        serve(-1, 16'h0000, 1'b0, 1'b0, 1'b1, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 1 || lat !== TO + 1 || ord !== 16'hFFFF || oerr !== 1'b1) begin
            failures++;
            $display("FAIL timeout got=owner%0d/lat%0d/%h/%b exp=owner1/lat%0d/ffff/1", who, lat, ord, oerr, TO + 1);
        end
        tick();
        req0_valid = 1; req0_wr = 0; req0_phy_addr = 5'h01; req0_reg_addr = 5'h03;
        serve(2, 16'h1234, 1'b0, 1'b1, 1'b0, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 0 || ord !== 16'h1234 || oerr !== 1'b0) begin
            failures++;
            $display("FAIL after_timeout got=owner%0d/%h/%b exp=owner0/1234/0", who, ord, oerr);
        end
        checks++;
        if ({req1_rdata, req1_err} !== {16'hFFFF, 1'b1}) begin
            failures++;
            $display("FAIL timeout_hold got=%h/%b exp=ffff/1", req1_rdata, req1_err);
        end
        tick();
    endtask

    task automatic test_nack();
        int phy, who, lat;
        logic [15:0] ord;
        logic oerr;
        mdio_done = 1; mdio_rdata = 16'h5555;
        tick();
        mdio_done = 0; mdio_rdata = 0;
        tick();
        checks++;
        if ({req0_done, req1_done, mdio_start} !== 3'b000) begin
            failures++;
            $display("FAIL stray_done got=%b exp=000", {req0_done, req1_done, mdio_start});
        end
        req1_valid = 1; req1_wr = 0; req1_phy_addr = 5'h02; req1_reg_addr = 5'h02;
        serve(4, 16'hFFFF, 1'b1, 1'b0, 1'b1, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 1 || ord !== 16'hFFFF || oerr !== 1'b1) begin
            failures++;
            $display("FAIL nack got=owner%0d/%h/%b exp=owner1/ffff/1", who, ord, oerr);
        end
        req0_valid = 1; req0_wr = 0; req0_phy_addr = 5'h01; req0_reg_addr = 5'h04;
        serve(TO, 16'h5A5A, 1'b0, 1'b1, 1'b0, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 0 || lat !== TO + 1 || ord !== 16'h5A5A || oerr !== 1'b0) begin
            failures++;
            $display("FAIL done_at_timeout got=owner%0d/lat%0d/%h/%b exp=owner0/lat%0d/5a5a/0", who, lat, ord, oerr, TO + 1);
        end
        req1_valid = 1; req1_wr = 0; req1_phy_addr = 5'h02; req1_reg_addr = 5'h05;
        serve(TO, 16'h0F0F, 1'b1, 1'b0, 1'b1, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 1 || ord !== 16'h0F0F || oerr !== 1'b1) begin
            failures++;
            $display("FAIL nack_at_timeout got=owner%0d/%h/%b exp=owner1/0f0f/1", who, ord, oerr);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int phy, who, lat;
        int dones;
        logic [15:0] ord;
        logic oerr;
        logic [67:0] outs;
        req0_valid = 1; req0_wr = 0; req0_phy_addr = 5'h01; req0_reg_addr = 5'h01;
        tick();
        req0_valid = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        outs = {req0_ready, req0_done, req0_rdata, req0_err, req1_ready, req1_done, req1_rdata, req1_err,
                mdio_start, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata};
        checks++;
        if (outs !== 68'h0) begin failures++; $display("FAIL midreset_outs got=%h exp=0", outs); end
        dones = 0;
        for (int i = 0; i < TO + 5; i++) begin
            tick();
            if (req0_done || req1_done || mdio_start) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        req0_valid = 1; req0_phy_addr = 5'h01;
        req1_valid = 1; req1_wr = 0; req1_phy_addr = 5'h02;
        serve(2, 16'h2222, 1'b0, 1'b1, 1'b1, phy, who, ord, oerr, lat);
        checks++;
        if (who !== 0 || phy !== 1) begin
            failures++;
            $display("FAIL midreset_first_grant got=owner%0d/phy%0d exp=owner0/phy1", who, phy);
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_nack();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
